// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//    Shares one UART_TX channel between NUM_REQ byte requesters. In IDLE a
//    round-robin search starting at rr_ptr picks the first requester with a
//    valid byte. That requester gets a combinational one-hot req_ready. On the
//    handshake the byte is registered onto TxData and a single-cycle TxStart
//    is issued. The arbiter then waits for TxDone, spends one GAP cycle
//    advancing the round-robin pointer, and returns to IDLE. A watchdog sets a
//    sticky timeout_err if TxDone does not arrive within TIMEOUT_CYC cycles of
//    TxStart. In that case the arbiter abandons the frame and re-arbitrates.
//
// Parameters:
//    NUM_REQ      number of requesters (2..8)
//    TIMEOUT_CYC  cycles allowed from TxStart to TxDone
//
// Ports:
//    pClk         system clock, rising edge
//    pReset       synchronous active-high reset
//    req_valid    per-requester byte valid
//    req_data     requester i byte at [8*i+7:8*i]
//    req_last     per-requester last-byte-of-packet flag (lock build only)
//    req_ready    one-hot combinational accept, only ever high in IDLE
//    TxData       registered byte to UART_TX, held until the next handshake
//    TxStart      registered single-cycle start pulse to UART_TX
//    TxDone       single-cycle completion pulse from UART_TX
//    grant_id     index of the current or last granted requester
//    busy         high whenever the FSM is not in IDLE
//    err_clr      clears timeout_err (a same-cycle set wins)
//    timeout_err  sticky watchdog flag
//
// Configuration:
//    UART_ARB_LOCK_EN  when defined, a handshake with req_last=0 locks the
//                      channel to that requester until it sends a byte with
//                      req_last=1. A timeout or reset also releases the lock.
//                      When undefined, req_last is ignored and the pointer
//                      rotates after every byte.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic                       pClk,
   input  logic                       pReset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [7:0]                 TxData,
   output logic                       TxStart,
   input  logic                       TxDone,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   input  logic                       err_clr,
   output logic                       timeout_err
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic             busy_q, busy_d;
   logic             timeout_err_q, timeout_err_d;
   logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;

`ifdef UART_ARB_LOCK_EN
   logic             lock_q, lock_d;
`else
   logic             unused_req_last;
`endif

   logic             win_found;
   logic [IDW-1:0]   win_idx;
   logic [IDW-1:0]   cand_idx;
   logic [IDW-1:0]   next_ptr;
   logic             handshake;
   logic             timeout_set;

`ifndef UART_ARB_LOCK_EN
   // Without the lock feature the packet boundary flag carries no meaning,
   // so it is folded into a sink signal to show it is deliberately unused.
   assign unused_req_last = ^req_last;
`endif

   // Round-robin winner search. The loop walks rr_ptr, rr_ptr+1, ... modulo
   // NUM_REQ and keeps the first valid requester it meets. The search
   // produces a winner even outside IDLE; req_ready gating happens below.
   // When the channel is locked, the search result is discarded and only the
   // locked requester may win. Everyone else waits, even when the locked
   // requester has nothing to send yet.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!win_found && req_valid[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
`ifdef UART_ARB_LOCK_EN
      if (lock_q) begin
         win_found = req_valid[grant_id_q];
         win_idx   = grant_id_q;
      end
`endif
   end

   // req_ready is a one-hot decode of the winner and is only offered in IDLE.
   // The winner is always a valid requester, so any ready bit is a handshake.
   always_comb begin
      req_ready = '0;
      if ((state_q == ST_IDLE) && win_found) begin
         req_ready[win_idx] = 1'b1;
      end
      handshake = |(req_ready & req_valid);
   end

   // The requester after the last grant, wrapping NUM_REQ-1 back to zero.
   // This is written out explicitly because NUM_REQ need not be a power of two.
   always_comb begin
      if (grant_id_q == IDW'(NUM_REQ - 1)) begin
         next_ptr = '0;
      end else begin
         next_ptr = grant_id_q + IDW'(1);
      end
   end

   // Next-state logic for the sequencer: IDLE -> START -> WAIT -> GAP -> IDLE.
   // TxStart is computed one cycle early (on the handshake) and then
   // registered, so the pulse coincides exactly with the START state.
   // TxDone is only looked at in WAIT, so stray pulses elsewhere, including
   // one left over from a frame that was in flight at reset, have no effect.
   // A TxDone arriving in the same cycle the watchdog expires is treated as
   // a normal completion.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_id_d    = grant_id_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      wd_cnt_d      = wd_cnt_q;
      timeout_set   = 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_d        = lock_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               tx_data_d  = req_data[{win_idx, 3'b000} +: 8];
               grant_id_d = win_idx;
               tx_start_d = 1'b1;
               state_d    = ST_START;
`ifdef UART_ARB_LOCK_EN
               lock_d     = ~req_last[win_idx];
`endif
            end
         end
         ST_START: begin
            wd_cnt_d = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            if (TxDone) begin
               state_d = ST_GAP;
            end else if (wd_cnt_q == WDW'(TIMEOUT_CYC - 1)) begin
               timeout_set = 1'b1;
               rr_ptr_d    = next_ptr;
               state_d     = ST_IDLE;
`ifdef UART_ARB_LOCK_EN
               lock_d      = 1'b0;
`endif
            end else begin
               wd_cnt_d = wd_cnt_q + WDW'(1);
            end
         end
         ST_GAP: begin
`ifdef UART_ARB_LOCK_EN
            if (!lock_q) begin
               rr_ptr_d = next_ptr;
            end
`else
            rr_ptr_d = next_ptr;
`endif
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);

      if (timeout_set) begin
         timeout_err_d = 1'b1;
      end else if (err_clr) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end
   end

   // All state and all outputs are registered in this single block. Reset is
   // synchronous and returns every register to its idle value. A frame
   // already handed to UART_TX is simply forgotten.
   always_ff @(posedge pClk) begin
      if (pReset) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         tx_data_q     <= 8'h00;
         tx_start_q    <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         wd_cnt_q      <= '0;
`ifdef UART_ARB_LOCK_EN
         lock_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         wd_cnt_q      <= wd_cnt_d;
`ifdef UART_ARB_LOCK_EN
         lock_q        <= lock_d;
`endif
      end
   end

   assign TxData      = tx_data_q;
   assign TxStart     = tx_start_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// This is a self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYC=50).
//
// Requesters are modelled as per-requester pending bytes that stay valid until
// accepted. They may occasionally withdraw a byte. A UART stand-in pulses
// TxDone a chosen number of cycles after TxStart. It can also stay silent or
// fire stray pulses.
//
// The reference model does not track FSM states. It tracks timestamps instead:
// the cycle at which the arbiter becomes eligible to accept again, the
// TxStart cycle, and the watchdog deadline. Every cycle it compares all
// outputs against these. Directed sections run first, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NR    = 4;
   localparam int TCYC  = 50;
   localparam int IW    = $clog2(NR);
   localparam int NEVER = 2147483647;

   logic              pClk = 1'b0;
   logic              pReset;
   logic [NR-1:0]     reqValid;
   logic [8*NR-1:0]   reqData;
   logic [NR-1:0]     reqLast;
   logic [NR-1:0]     reqReady;
   logic [7:0]        txData;
   logic              txStart;
   logic              txDone;
   logic [IW-1:0]     grantId;
   logic              busy;
   logic              errClr;
   logic              timeoutErr;

   int checkCount = 0;
   int errorCount = 0;
   int cyc;

   bit         pendV[NR];
   logic [7:0] pendD[NR];
   bit         pendL[NR];
   int         doneAt;
   int         strayAt;
   int         doneDelay;
   bit         autoRequest;
   bit         randomDone;

   int         eligible;
   int         startCyc;
   int         deadline;
   int         ptrM;
   int         grantM;
   logic [7:0] dataM;
   bit         waiting;
   bit         errM;
   bit         lockM;

   int dutOrder[$];
   int expOrder[4];
   int sent0;

   uart_tx_arbiter #(
      .NUM_REQ     (NR),
      .TIMEOUT_CYC (TCYC)
   ) dut (
      .pClk        (pClk),
      .pReset      (pReset),
      .req_valid   (reqValid),
      .req_data    (reqData),
      .req_last    (reqLast),
      .req_ready   (reqReady),
      .TxData      (txData),
      .TxStart     (txStart),
      .TxDone      (txDone),
      .grant_id    (grantId),
      .busy        (busy),
      .err_clr     (errClr),
      .timeout_err (timeoutErr)
   );

   // A free-running 10-time-unit clock.
   always #5 pClk = ~pClk;

   // Single comparison point: counts every check and reports each mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)",
                  tag, observed, expected, cyc);
      end
   endtask

   // Round-robin rule. Take the first pending requester counting up from the
   // pointer. While locked, only the locked owner may be chosen.
   function automatic int pickWinner();
      if (lockM) begin
         return pendV[grantM] ? grantM : -1;
      end
      for (int k = 0; k < NR; k++) begin
         if (pendV[(ptrM + k) % NR]) begin
            return (ptrM + k) % NR;
         end
      end
      return -1;
   endfunction

   // Return the model to its post-reset state.
   // The arbiter accepts again from 'fromCyc'.
   task automatic modelReset(input int fromCyc);
      eligible = fromCyc;
      startCyc = -10;
      deadline = -10;
      ptrM     = 0;
      grantM   = 0;
      dataM    = 8'h00;
      waiting  = 1'b0;
      errM     = 1'b0;
      lockM    = 1'b0;
   endtask

   // One clock cycle. Drive inputs just after the rising edge, then compare
   // outputs on the falling edge. Next, advance the reference model and the
   // requester/UART stand-ins. Finally, step to the next rising edge.
   task automatic applyStimulus(input bit rst, input bit clr);
      bit            idleM;
      bit            errSet;
      int            w;
      logic [NR-1:0] expReady;

      pReset = rst;
      errClr = clr;
      for (int i = 0; i < NR; i++) begin
         reqValid[i]      = pendV[i];
         reqData[8*i +: 8] = pendV[i] ? pendD[i] : 8'($urandom);
         reqLast[i]       = pendL[i];
      end
      txDone = (cyc == doneAt) || (cyc == strayAt);

      @(negedge pClk);
      idleM    = (cyc >= eligible);
      w        = idleM ? pickWinner() : -1;
      expReady = '0;
      if (w >= 0) begin
         expReady[w] = 1'b1;
      end
      checkOutput("req_ready", 32'(reqReady), 32'(expReady));
      checkOutput("busy", 32'(busy), 32'(!idleM));
      checkOutput("TxStart", 32'(txStart), 32'(cyc == startCyc));
      checkOutput("TxData", 32'(txData), 32'(dataM));
      checkOutput("grant_id", 32'(grantId), 32'(grantM));
      checkOutput("timeout_err", 32'(timeoutErr), 32'(errM));

      if (!rst) begin
         for (int i = 0; i < NR; i++) begin
            if (reqValid[i] && reqReady[i]) begin
               dutOrder.push_back(i);
            end
         end
      end

      if (rst) begin
         modelReset(cyc + 1);
      end else begin
         errSet = 1'b0;
         if (waiting && txDone && (cyc > startCyc) && (cyc <= deadline)) begin
            waiting  = 1'b0;
            eligible = cyc + 2;
            if (!lockM) begin
               ptrM = (grantM + 1) % NR;
            end
         end else if (waiting && (cyc == deadline)) begin
            waiting  = 1'b0;
            eligible = cyc + 1;
            ptrM     = (grantM + 1) % NR;
            lockM    = 1'b0;
            errSet   = 1'b1;
         end
         if (errSet) begin
            errM = 1'b1;
         end else if (clr) begin
            errM = 1'b0;
         end
         if (w >= 0) begin
            grantM   = w;
            dataM    = pendD[w];
            startCyc = cyc + 1;
            deadline = cyc + 1 + TCYC;
            waiting  = 1'b1;
            eligible = NEVER;
`ifdef UART_ARB_LOCK_EN
            lockM    = !pendL[w];
`endif
            pendV[w] = 1'b0;
            if (randomDone) begin
               doneDelay = ($urandom_range(0, 99) < 4) ? 0 : $urandom_range(1, TCYC);
            end
            doneAt = (doneDelay > 0) ? (startCyc + doneDelay) : -1;
         end
      end

      if (autoRequest) begin
         for (int i = 0; i < NR; i++) begin
            if (!pendV[i] && ($urandom_range(0, 99) < 25)) begin
               pendV[i] = 1'b1;
               pendD[i] = 8'($urandom);
               pendL[i] = 1'($urandom_range(0, 1));
            end else if (pendV[i] && ($urandom_range(0, 99) < 2)) begin
               pendV[i] = 1'b0;
            end
         end
         if ($urandom_range(0, 99) < 3) begin
            strayAt = cyc + $urandom_range(1, 5);
         end
      end

      @(posedge pClk);
      #1;
      cyc++;
   endtask

   initial begin
      pReset   = 1'b1;
      errClr   = 1'b0;
      txDone   = 1'b0;
      reqValid = '0;
      reqData  = '0;
      reqLast  = '0;
      for (int i = 0; i < NR; i++) begin
         pendV[i] = 1'b0;
         pendD[i] = 8'h00;
         pendL[i] = 1'b1;
      end
      doneAt      = -1;
      strayAt     = -1;
      doneDelay   = 10;
      autoRequest = 1'b0;
      randomDone  = 1'b0;
      cyc         = 0;
      modelReset(0);
      repeat (2) @(posedge pClk);
      #1;

      $display("[TB] reset values and single requester");
      pendV[0] = 1'b1;
      pendD[0] = 8'hA5;
      repeat (16) applyStimulus(1'b0, 1'b0);

      $display("[TB] all requesters valid, rotation order");
      applyStimulus(1'b1, 1'b0);
      dutOrder.delete();
      for (int i = 0; i < NR; i++) begin
         pendV[i] = 1'b1;
         pendD[i] = 8'(8'h10 + i);
         pendL[i] = 1'b1;
      end
      doneDelay = 20;
      repeat (94) applyStimulus(1'b0, 1'b0);
      pendV[0] = 1'b1;
      pendD[0] = 8'h10;
      repeat (25) applyStimulus(1'b0, 1'b0);
      expOrder[0] = 0;
      expOrder[1] = 1;
      expOrder[2] = 2;
      expOrder[3] = 3;
      checkOutput("rr_order_len", 32'(dutOrder.size()), 32'd5);
      for (int k = 0; k < 4 && k < dutOrder.size(); k++) begin
         checkOutput("rr_order", 32'(dutOrder[k]), 32'(expOrder[k]));
      end
      if (dutOrder.size() >= 5) begin
         checkOutput("rr_wrap", 32'(dutOrder[4]), 32'd0);
      end

      $display("[TB] watchdog timeout and err_clr");
      doneDelay = 0;
      pendV[1]  = 1'b1;
      pendD[1]  = 8'h3C;
      repeat (TCYC + 6) applyStimulus(1'b0, 1'b0);
      checkOutput("timeout_set", 32'(timeoutErr), 32'd1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("timeout_clr", 32'(timeoutErr), 32'd0);
      pendV[1] = 1'b1;
      for (int n = 0; n < 200 && !(waiting && cyc == deadline); n++) begin
         applyStimulus(1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1);
      checkOutput("set_beats_clr", 32'(timeoutErr), 32'd1);
      applyStimulus(1'b0, 1'b1);
      doneDelay = TCYC;
      pendV[2]  = 1'b1;
      pendD[2]  = 8'h5A;
      repeat (TCYC + 6) applyStimulus(1'b0, 1'b0);
      checkOutput("done_on_deadline", 32'(timeoutErr), 32'd0);

      $display("[TB] reset while waiting for TxDone");
      doneDelay = 30;
      pendV[2]  = 1'b1;
      pendD[2]  = 8'hC3;
      repeat (6) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      repeat (40) applyStimulus(1'b0, 1'b0);

      $display("[TB] stray TxDone in IDLE and START");
      strayAt = cyc;
      applyStimulus(1'b0, 1'b0);
      doneDelay = 12;
      pendV[3]  = 1'b1;
      pendD[3]  = 8'h77;
      strayAt   = cyc;
      applyStimulus(1'b0, 1'b0);
      strayAt = cyc;
      applyStimulus(1'b0, 1'b0);
      repeat (16) applyStimulus(1'b0, 1'b0);

      $display("[TB] multi-byte packet from requester 0 against requester 1");
      applyStimulus(1'b1, 1'b0);
      dutOrder.delete();
      doneDelay = 5;
      sent0     = 0;
      pendV[0]  = 1'b1;
      pendD[0]  = 8'h50;
      pendL[0]  = 1'b0;
      pendV[1]  = 1'b1;
      pendD[1]  = 8'h60;
      pendL[1]  = 1'b1;
      for (int n = 0; n < 200 && dutOrder.size() < 4; n++) begin
         applyStimulus(1'b0, 1'b0);
         if (!pendV[0] && sent0 < 2) begin
            sent0++;
            pendV[0] = 1'b1;
            pendD[0] = 8'(8'h50 + sent0);
            pendL[0] = (sent0 == 2);
         end
         if (!pendV[1]) begin
            pendV[1] = 1'b1;
            pendD[1] = 8'h61;
            pendL[1] = 1'b1;
         end
      end
`ifdef UART_ARB_LOCK_EN
      expOrder[0] = 0;
      expOrder[1] = 0;
      expOrder[2] = 0;
      expOrder[3] = 1;
`else
      expOrder[0] = 0;
      expOrder[1] = 1;
      expOrder[2] = 0;
      expOrder[3] = 1;
`endif
      checkOutput("pkt_order_len", 32'(dutOrder.size()), 32'd4);
      for (int k = 0; k < 4 && k < dutOrder.size(); k++) begin
         checkOutput("pkt_order", 32'(dutOrder[k]), 32'(expOrder[k]));
      end

      $display("[TB] randomized traffic");
      applyStimulus(1'b1, 1'b0);
      autoRequest = 1'b1;
      randomDone  = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(1'($urandom_range(0, 999) < 2), 1'($urandom_range(0, 99) < 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
